// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALUControl encodings and FSM state type for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int CONTROL_WIDTH = 3;

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND = 3'b010;
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = 3'b011;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLL = 3'b100;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLT = 3'b101;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRL = 3'b110;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRA = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shifter
// Description : Iterative shifter, SHIFT_STEP bits per cycle. Right shifts
//               exist only when ALU_SHIFT_RIGHT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
`ifdef ALU_SHIFT_RIGHT_EN
    input  logic                          load_right,
    input  logic                          load_arith,
`endif
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic [$clog2(DATA_WIDTH)-1:0] load_amt,
    output logic                          done,
    output logic [DATA_WIDTH-1:0]         result
);

    // One extra bit so SHIFT_STEP == DATA_WIDTH is representable.
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_STEP = CNT_W'(SHIFT_STEP);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0]      w_step_amt;
    logic [DATA_WIDTH-1:0] w_shifted;

`ifdef ALU_SHIFT_RIGHT_EN
    logic right_q, right_d;
    logic arith_q, arith_d;
`endif

    always_comb begin
        w_step_amt = (remaining_q < C_STEP) ? remaining_q : C_STEP;
        w_shifted  = shreg_q << w_step_amt;
`ifdef ALU_SHIFT_RIGHT_EN
        if (right_q) begin
            w_shifted = arith_q ? DATA_WIDTH'($signed(shreg_q) >>> w_step_amt)
                                : (shreg_q >> w_step_amt);
        end
`endif
    end

    always_comb begin
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
`ifdef ALU_SHIFT_RIGHT_EN
        right_d     = right_q;
        arith_d     = arith_q;
`endif
        if (load) begin
            shreg_d     = load_data;
            remaining_d = {1'b0, load_amt};
`ifdef ALU_SHIFT_RIGHT_EN
            right_d     = load_right;
            arith_d     = load_arith;
`endif
        end else if (remaining_q != '0) begin
            shreg_d     = w_shifted;
            remaining_d = remaining_q - w_step_amt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            remaining_q <= '0;
`ifdef ALU_SHIFT_RIGHT_EN
            right_q     <= 1'b0;
            arith_q     <= 1'b0;
`endif
        end else begin
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
`ifdef ALU_SHIFT_RIGHT_EN
            right_q     <= right_d;
            arith_q     <= arith_d;
`endif
        end
    end

    // The coming edge is the last step when what is left fits in one step.
    assign done   = (remaining_q != '0) && (remaining_q <= C_STEP);
    assign result = w_shifted;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshake, 1-cycle ops and
//               iterative shifts. Macro ALU_SHIFT_RIGHT_EN adds srl/sra.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = alu_pkg::CONTROL_WIDTH,
    parameter int SHIFT_STEP    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CONTROL_WIDTH-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Zero
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    alu_state_t            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;

    logic                  w_accept;
    logic                  w_is_shift;
    logic                  w_load;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_op_result;
    logic                  w_shift_done;
    logic [DATA_WIDTH-1:0] w_shift_result;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_shamt  = SrcB[SHAMT_W-1:0];

    always_comb begin
        w_op_result = '0;
        case (ALUControl)
            ALU_ADD: w_op_result = SrcA + SrcB;
            ALU_SUB: w_op_result = SrcA - SrcB;
            ALU_AND: w_op_result = SrcA & SrcB;
            ALU_OR:  w_op_result = SrcA | SrcB;
            ALU_SLT: w_op_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            // Only reached as a result when the shift amount is zero.
            ALU_SLL: w_op_result = SrcA;
`ifdef ALU_SHIFT_RIGHT_EN
            ALU_SRL: w_op_result = SrcA;
            ALU_SRA: w_op_result = SrcA;
`endif
            default: w_op_result = '0;
        endcase
    end

`ifdef ALU_SHIFT_RIGHT_EN
    assign w_is_shift = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL) ||
                        (ALUControl == ALU_SRA);
`else
    assign w_is_shift = (ALUControl == ALU_SLL);
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        w_load      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_load  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d    = w_op_result;
                        zero_d      = (w_op_result == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    result_d    = w_shift_result;
                    zero_d      = (w_shift_result == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    alu_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
`ifdef ALU_SHIFT_RIGHT_EN
        .load_right ((ALUControl == ALU_SRL) || (ALUControl == ALU_SRA)),
        .load_arith (ALUControl == ALU_SRA),
`endif
        .load_data  (SrcA),
        .load_amt   (w_shamt),
        .done       (w_shift_done),
        .result     (w_shift_result)
    );

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit with a latency-level
//               reference model for randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int DW   = 32;
    localparam int STEP = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ALUControl;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ALUResult;
    logic          Zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .DATA_WIDTH    (DW),
        .CONTROL_WIDTH (3),
        .SHIFT_STEP    (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_result(input logic [2:0] op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        int sh;
        sh = int'(b % DW);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a << sh;
            3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_SHIFT_RIGHT_EN
            3'd6: return a >> sh;
            3'd7: return DW'($signed(a) >>> sh);
`endif
            default: return '0;
        endcase
    endfunction

    function automatic bit ref_is_shift(input logic [2:0] op);
`ifdef ALU_SHIFT_RIGHT_EN
        return (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
`else
        return (op == 3'd4);
`endif
    endfunction

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = '0; SrcA = '0; SrcB = '0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ALUResult !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", ALUResult); end
        n_cmp++; if (Zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", Zero); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (ALUResult !== '0 || Zero !== 1'b0) begin n_err++; $display("FAIL idle_result: got %h/%b want 0/0", ALUResult, Zero); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(3'd0, 32'd5, 32'd7);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== 32'd12 || Zero !== 1'b0) begin
            n_err++; $display("FAIL b2b_add: got v=%b r=%h z=%b want 1/c/0", out_valid, ALUResult, Zero); end
        drive(3'd1, 32'd7, 32'd7);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            n_err++; $display("FAIL b2b_sub: got v=%b r=%h z=%b want 1/0/1", out_valid, ALUResult, Zero); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || ALUResult !== 32'd0) begin
            n_err++; $display("FAIL b2b_drain: got v=%b r=%h want 0/0", out_valid, ALUResult); end
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        drive(3'd5, 32'hFFFF_FFFF, 32'd1);
        tick();
        n_cmp++; if (ALUResult !== 32'd1 || Zero !== 1'b0) begin n_err++; $display("FAIL slt_neg: got %h/%b want 1/0", ALUResult, Zero); end
        drive(3'd5, 32'd1, 32'hFFFF_FFFF);
        tick();
        n_cmp++; if (ALUResult !== 32'd0 || Zero !== 1'b1) begin n_err++; $display("FAIL slt_pos: got %h/%b want 0/1", ALUResult, Zero); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic wait_shift(input string name, input int exp_edges, input logic [DW-1:0] exp_res);
        int edges = 0;
        while (!out_valid && edges < 100) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s_busy: in_ready got %b want 0 at edge %0d", name, in_ready, edges); end
            tick();
            edges++;
        end
        n_cmp++; if (edges !== exp_edges) begin n_err++; $display("FAIL %s_latency: got %0d edges want %0d", name, edges, exp_edges); end
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== exp_res) begin
            n_err++; $display("FAIL %s_result: got v=%b r=%h want 1/%h", name, out_valid, ALUResult, exp_res); end
    endtask

    task automatic test_sll();
        out_ready = 1'b1;
        drive(3'd4, 32'h3, 32'h25);
        tick();
        in_valid = 1'b0;
        wait_shift("sll", (5 + STEP - 1) / STEP, 32'h60);
        tick();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(3'd0, 32'd10, 32'd20);
        tick();
        drive(3'd3, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUResult !== 32'd30) begin
                n_err++; $display("FAIL hold_%0d: got rdy=%b v=%b r=%h want 0/1/1e", i, in_ready, out_valid, ALUResult); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== 32'd3) begin
            n_err++; $display("FAIL hold_accept: got v=%b r=%h want 1/3", out_valid, ALUResult); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        drive(3'd4, 32'h1, 32'd8);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || ALUResult !== '0 || Zero !== 1'b0) begin
            n_err++; $display("FAIL rstmid_state: got v=%b r=%h z=%b want 0/0/0", out_valid, ALUResult, Zero); end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_result: out_valid got %b want 0 at %0d", out_valid, i); end
        end
        drive(3'd0, 32'd1, 32'd1);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== 32'd2) begin
            n_err++; $display("FAIL rstmid_add: got v=%b r=%h want 1/2", out_valid, ALUResult); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_upper_codes();
        out_ready = 1'b1;
`ifdef ALU_SHIFT_RIGHT_EN
        drive(3'd7, 32'h8000_0000, 32'd4);
        tick();
        in_valid = 1'b0;
        wait_shift("sra", (4 + STEP - 1) / STEP, 32'hF800_0000);
        tick();
        drive(3'd6, 32'h8000_0000, 32'hFFFF_FFE4);
        tick();
        in_valid = 1'b0;
        wait_shift("srl", (4 + STEP - 1) / STEP, 32'h0800_0000);
        tick();
`else
        drive(3'd6, 32'h1234_5678, 32'd4);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== '0 || Zero !== 1'b1) begin
            n_err++; $display("FAIL code110: got v=%b r=%h z=%b want 1/0/1", out_valid, ALUResult, Zero); end
        drive(3'd7, 32'h8000_0000, 32'd4);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== '0 || Zero !== 1'b1) begin
            n_err++; $display("FAIL code111: got v=%b r=%h z=%b want 1/0/1", out_valid, ALUResult, Zero); end
        in_valid = 1'b0;
        tick();
`endif
    endtask

    task automatic test_random();
        bit            m_valid = 1'b0;
        logic [DW-1:0] m_res = '0;
        int            m_busy = 0;
        logic [DW-1:0] m_shres = '0;
        bit            exp_ready, acc;
        logic [DW-1:0] r;
        int            sh;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            ALUControl = 3'($urandom_range(0, 7));
            SrcA       = $urandom();
            SrcB       = ($urandom_range(0, 7) == 0) ? SrcA : $urandom();
            if ($urandom_range(0, 3) == 0) SrcB[4:0] = 5'd0;
            #1;
            exp_ready = (m_busy == 0) && (!m_valid || out_ready);
            n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, exp_ready); end
            n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_out_valid@%0d: got %b want %b", cyc, out_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if (ALUResult !== m_res || Zero !== (m_res == '0)) begin
                    n_err++; $display("FAIL rnd_result@%0d: got %h/%b want %h/%b", cyc, ALUResult, Zero, m_res, (m_res == '0)); end
            end
            acc = in_valid && exp_ready;
            r   = ref_result(ALUControl, SrcA, SrcB);
            sh  = int'(SrcB % DW);
            tick();
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin m_valid = 1'b1; m_res = m_shres; end
            end
            if (acc) begin
                if (ref_is_shift(ALUControl) && sh != 0) begin
                    m_busy  = (sh + STEP - 1) / STEP;
                    m_shres = r;
                end else begin
                    m_valid = 1'b1;
                    m_res   = r;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_slt();
        test_sll();
        test_hold();
        test_reset_mid_shift();
        test_upper_codes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
